// File: rtl/iir_cas_sched_if.sv
// Bundle between the cascade scheduler (master) and its surroundings (slave):
// sample input handshake, shared-section control, and filtered output.
interface iir_cas_sched_if #(
    parameter int NSTAGE = 4,
    parameter int DW     = 12,
    parameter int SW     = 16
);
    localparam int STW = $clog2(NSTAGE);

    logic                  din_vld;
    logic signed [DW-1:0]  din;
    logic                  din_rdy;
    logic                  sec_start;
    logic [STW-1:0]        sec_stage;
    logic signed [SW-1:0]  sec_x;
    logic                  sec_done;
    logic signed [SW-1:0]  sec_y;
    logic                  sec_flush;
    logic                  dout_vld;
    logic signed [DW-1:0]  dout;
    logic                  sat;
    logic                  err;
    logic                  busy;

    modport master (
        input  din_vld, din, sec_done, sec_y,
        output din_rdy, sec_start, sec_stage, sec_x, sec_flush,
        output dout_vld, dout, sat, err, busy
    );

    modport slave (
        output din_vld, din, sec_done, sec_y,
        input  din_rdy, sec_start, sec_stage, sec_x, sec_flush,
        input  dout_vld, dout, sat, err, busy
    );
endinterface

// File: rtl/iir_cas_sched.sv
// Time-multiplexes one shared second-order section over NSTAGE cascade stages,
// chaining each stage result into the next and saturating the final result.
module iir_cas_sched #(
    parameter int NSTAGE = 4,
    parameter int DW     = 12,
    parameter int SW     = 16,
    parameter int TMO    = 15
) (
    input  logic            clk,
    input  logic            rst,
    iir_cas_sched_if.master bus
);
    localparam int STW = $clog2(NSTAGE);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (DW-1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t               state_q, state_d;
    logic [STW-1:0]       stage_q, stage_d;
    logic signed [SW-1:0] opnd_q, opnd_d;
    logic [7:0]           cnt_q, cnt_d;
    logic signed [DW-1:0] dout_q, dout_d;
    logic                 dout_vld_q, dout_vld_d;
    logic                 sat_q, sat_d;
    logic                 err_q, err_d;
    logic                 start_q, start_d;
    logic                 flush_q, flush_d;
    logic                 rst_q;

    function automatic logic signed [DW-1:0] sat_val(input logic signed [SW-1:0] x);
        if (x > MAXV)      return MAXV[DW-1:0];
        else if (x < MINV) return MINV[DW-1:0];
        else               return x[DW-1:0];
    endfunction

    function automatic logic sat_flag(input logic signed [SW-1:0] x);
        return (x > MAXV) || (x < MINV);
    endfunction

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        sat_d      = 1'b0;
        err_d      = 1'b0;
        start_d    = 1'b0;
        // Flush only on the first reset cycle, not for the whole reset window.
        flush_d    = rst & ~rst_q;

        case (state_q)
            IDLE: begin
                if (bus.din_vld) begin
                    opnd_d  = {{(SW-DW){bus.din[DW-1]}}, bus.din};
                    stage_d = '0;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.sec_done) begin
                    opnd_d = bus.sec_y;
                    if (stage_q == STW'(NSTAGE - 1)) begin
                        dout_d     = sat_val(bus.sec_y);
                        sat_d      = sat_flag(bus.sec_y);
                        dout_vld_d = 1'b1;
                        state_d    = OUT;
                    end else begin
                        stage_d = stage_q + STW'(1);
                        start_d = 1'b1;
                        state_d = ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(TMO)) begin
                        err_d   = 1'b1;
                        flush_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q   <= rst;
        flush_q <= flush_d;
        if (rst) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            sat_q      <= sat_d;
            err_q      <= err_d;
            start_q    <= start_d;
        end
    end

    assign bus.din_rdy   = (state_q == IDLE) && !rst;
    assign bus.busy      = (state_q != IDLE);
    assign bus.sec_start = start_q;
    assign bus.sec_stage = stage_q;
    assign bus.sec_x     = opnd_q;
    assign bus.sec_flush = flush_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.dout      = dout_q;
    assign bus.sat       = sat_q;
    assign bus.err       = err_q;
endmodule
